ibex_sram_arbiter: RTL and testbench

- Shares one single-port, 1-cycle-read-latency SRAM between the Ibex instruction and data ports.
- Sits between the core's instr/data request interfaces and the RAM macro. It replaces ad-hoc arbitration glue.
- Provides round-robin arbitration, address-window decode, error responses for out-of-window accesses, and response routing back to the requesting port.

---
 rtl/ibex_sram_arbiter_if.sv | 49 ++++
 rtl/ibex_sram_arbiter.sv | 139 +++++++++++++
 tb/tb_ibex_sram_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_sram_arbiter_if.sv
// Bus bundle between the Ibex instr/data request ports, the SRAM arbiter and
// the single-port RAM macro. The slave modport is the arbiter's view; the
// master modport is the view of the core plus RAM that surround it.
interface ibex_sram_arbiter_if #(
  parameter int AddrWidth = 14
);
  // Instruction port
  logic                 instr_req_i;
  logic [31:0]          instr_addr_i;
  logic                 instr_gnt_o;
  logic                 instr_rvalid_o;
  logic [31:0]          instr_rdata_o;
  logic                 instr_err_o;
  // Data port
  logic                 data_req_i;
  logic                 data_we_i;
  logic [3:0]           data_be_i;
  logic [31:0]          data_addr_i;
  logic [31:0]          data_wdata_i;
  logic                 data_gnt_o;
  logic                 data_rvalid_o;
  logic [31:0]          data_rdata_o;
  logic                 data_err_o;
  // RAM macro port
  logic                 ram_req_o;
  logic                 ram_we_o;
  logic [3:0]           ram_be_o;
  logic [AddrWidth-1:0] ram_addr_o;
  logic [31:0]          ram_wdata_o;
  logic [31:0]          ram_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
    input  ram_rdata_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
    output ram_rdata_i
  );
endinterface

// File: rtl/ibex_sram_arbiter.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency SRAM between
// the Ibex instruction and data ports. Out-of-window accesses are granted but
// never reach the RAM; they are answered with an error response instead.
module ibex_sram_arbiter #(
  parameter int          MemSize   = 65536,
  parameter logic [31:0] MemStart  = 32'h00000000,
  parameter int          AddrWidth = $clog2(MemSize / 4)
) (
  input logic clk_i,
  input logic rst_i,
  ibex_sram_arbiter_if.slave bus
);

  typedef enum logic {
    PortInstr = 1'b0,
    PortData  = 1'b1
  } port_e;

  localparam logic [31:0] MemMask = ~(32'(MemSize) - 32'd1);

  function automatic logic in_window(input logic [31:0] addr);
    return (addr & MemMask) == MemStart;
  endfunction

  logic        instr_gnt;
  logic        data_gnt;
  logic        any_gnt;
  logic        contended;
  logic [31:0] sel_addr;
  logic        sel_in_range;
  logic        sel_write;

  port_e prio_q,        prio_d;
  logic  resp_valid_q,  resp_valid_d;
  port_e resp_port_q,   resp_port_d;
  logic  resp_err_q,    resp_err_d;
  logic  resp_rd_q,     resp_rd_d;

  // Grant selection: uncontended requests win outright, contention goes to
  // the port that did not win the previous contention. Nothing is granted in reset.
  always_comb begin
    instr_gnt = 1'b0;
    data_gnt  = 1'b0;
    contended = bus.instr_req_i & bus.data_req_i;
    if (!rst_i) begin
      if (contended) begin
        if (prio_q == PortInstr) data_gnt = 1'b1;
        else                     instr_gnt = 1'b1;
      end else begin
        instr_gnt = bus.instr_req_i;
        data_gnt  = bus.data_req_i;
      end
    end
  end

  assign any_gnt      = instr_gnt | data_gnt;
  assign sel_addr     = data_gnt ? bus.data_addr_i : bus.instr_addr_i;
  assign sel_in_range = in_window(sel_addr);
  assign sel_write    = data_gnt & bus.data_we_i;

  assign bus.instr_gnt_o = instr_gnt;
  assign bus.data_gnt_o  = data_gnt;

  // RAM request drive: the RAM bus is quiet (all zero) whenever nothing is granted.
  always_comb begin
    bus.ram_req_o   = 1'b0;
    bus.ram_we_o    = 1'b0;
    bus.ram_be_o    = 4'h0;
    bus.ram_addr_o  = '0;
    bus.ram_wdata_o = 32'h0;
    if (any_gnt) begin
      bus.ram_req_o  = sel_in_range;
      bus.ram_addr_o = sel_addr[AddrWidth+1:2];
      if (data_gnt) begin
        bus.ram_we_o    = bus.data_we_i;
        bus.ram_be_o    = bus.data_be_i;
        bus.ram_wdata_o = bus.data_wdata_i;
      end else begin
        bus.ram_be_o    = 4'hF;
      end
    end
  end

  // Next-state for the response stage and the contention pointer.
  always_comb begin
    resp_valid_d = any_gnt;
    resp_port_d  = resp_port_q;
    resp_err_d   = resp_err_q;
    resp_rd_d    = resp_rd_q;
    prio_d       = prio_q;
    if (any_gnt) begin
      resp_port_d = data_gnt ? PortData : PortInstr;
      resp_err_d  = ~sel_in_range;
      resp_rd_d   = sel_in_range & ~sel_write;
    end
    if (contended && any_gnt) begin
      prio_d = data_gnt ? PortData : PortInstr;
    end
  end

  // Response stage registers; reset discards any response still in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_valid_q <= 1'b0;
      resp_port_q  <= PortInstr;
      resp_err_q   <= 1'b0;
      resp_rd_q    <= 1'b0;
      prio_q       <= PortInstr;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_port_q  <= resp_port_d;
      resp_err_q   <= resp_err_d;
      resp_rd_q    <= resp_rd_d;
      prio_q       <= prio_d;
    end
  end

  // Response routing: only the port that was granted last cycle sees anything.
  always_comb begin
    bus.instr_rvalid_o = 1'b0;
    bus.instr_err_o    = 1'b0;
    bus.instr_rdata_o  = 32'h0;
    bus.data_rvalid_o  = 1'b0;
    bus.data_err_o     = 1'b0;
    bus.data_rdata_o   = 32'h0;
    if (resp_valid_q) begin
      if (resp_port_q == PortData) begin
        bus.data_rvalid_o = 1'b1;
        bus.data_err_o    = resp_err_q;
        bus.data_rdata_o  = resp_rd_q ? bus.ram_rdata_i : 32'h0;
      end else begin
        bus.instr_rvalid_o = 1'b1;
        bus.instr_err_o    = resp_err_q;
        bus.instr_rdata_o  = resp_rd_q ? bus.ram_rdata_i : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_ibex_sram_arbiter.sv
// Scoreboard bench for ibex_sram_arbiter: a grant checker predicts each
// response from a word-array memory model and queues it; an independent
// monitor pops and compares whenever a response appears.
module tb_ibex_sram_arbiter;
  localparam int MemSize = 65536;
  localparam int Words   = MemSize / 4;
  localparam int AW      = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ibex_sram_arbiter_if #(.AddrWidth(AW)) bus ();

  ibex_sram_arbiter #(
    .MemSize  (MemSize),
    .MemStart (32'h00000000),
    .AddrWidth(AW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    int          due;
    bit          port;   // 0 = instr, 1 = data
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  int          nchecks = 0;
  int          nerrors = 0;
  int          cyc = 0;
  int          ncontend = 0;
  logic [31:0] sram    [Words];
  logic [31:0] ref_mem [Words];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM macro stand-in: 1-cycle read latency, byte-enabled writes.
  always @(posedge clk) begin
    if (bus.ram_req_o) begin
      if (bus.ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_be_o[b]) sram[bus.ram_addr_o][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
      end else begin
        bus.ram_rdata_i <= sram[bus.ram_addr_o];
      end
    end
  end

  // Grant-cycle prediction: who wins, what the RAM sees, what comes back.
  task automatic check_grant();
    bit          ir, dr, exp_i, exp_d, inr, wr;
    logic [31:0] addr, rd, word;
    int          widx;
    ir = bus.instr_req_i;
    dr = bus.data_req_i;
    if (ir && dr) begin
      // contention winners alternate, data first after reset
      exp_d = (ncontend % 2 == 0);
      exp_i = !exp_d;
      ncontend++;
    end else begin
      exp_i = ir;
      exp_d = dr;
    end
    chk("instr_gnt", 32'(bus.instr_gnt_o), 32'(exp_i));
    chk("data_gnt",  32'(bus.data_gnt_o),  32'(exp_d));
    if (exp_i || exp_d) begin
      addr = exp_d ? bus.data_addr_i : bus.instr_addr_i;
      inr  = (addr / MemSize) == 0;
      wr   = exp_d && bus.data_we_i;
      widx = int'((addr % MemSize) / 4);
      chk("ram_req", 32'(bus.ram_req_o), 32'(inr));
      if (inr) begin
        chk("ram_addr", 32'(bus.ram_addr_o), widx);
        chk("ram_we",   32'(bus.ram_we_o), 32'(wr));
        chk("ram_be",   32'(bus.ram_be_o), exp_d ? 32'(bus.data_be_i) : 32'hF);
        if (wr) chk("ram_wdata", bus.ram_wdata_o, bus.data_wdata_i);
      end
      rd = 32'h0;
      if (inr && !wr) rd = ref_mem[widx];
      if (inr && wr) begin
        word = ref_mem[widx];
        for (int b = 0; b < 4; b++)
          if (bus.data_be_i[b]) word[8*b +: 8] = bus.data_wdata_i[8*b +: 8];
        ref_mem[widx] = word;
      end
      q.push_back('{due: cyc + 1, port: exp_d, err: !inr, rdata: rd});
    end else begin
      chk("idle_ram_req",   32'(bus.ram_req_o), 32'h0);
      chk("idle_ram_addr",  32'(bus.ram_addr_o), 32'h0);
      chk("idle_ram_we",    32'(bus.ram_we_o), 32'h0);
      chk("idle_ram_be",    32'(bus.ram_be_o), 32'h0);
      chk("idle_ram_wdata", bus.ram_wdata_o, 32'h0);
    end
  endtask

  // Response monitor: pops one expectation per observed response.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_instr_gnt",    32'(bus.instr_gnt_o), 32'h0);
      chk("rst_data_gnt",     32'(bus.data_gnt_o), 32'h0);
      chk("rst_instr_rvalid", 32'(bus.instr_rvalid_o), 32'h0);
      chk("rst_data_rvalid",  32'(bus.data_rvalid_o), 32'h0);
      chk("rst_ram_req",      32'(bus.ram_req_o), 32'h0);
      chk("rst_rdata",        bus.instr_rdata_o | bus.data_rdata_o, 32'h0);
    end else if (bus.instr_rvalid_o || bus.data_rvalid_o) begin
      chk("single_rvalid", 32'(bus.instr_rvalid_o & bus.data_rvalid_o), 32'h0);
      if (q.size() == 0) begin
        chk("unexpected_rvalid", 32'h1, 32'h0);
      end else begin
        e = q.pop_front();
        chk("resp_latency", cyc, e.due);
        chk("resp_port", 32'(bus.data_rvalid_o), 32'(e.port));
        if (e.port) begin
          chk("data_err",    32'(bus.data_err_o), 32'(e.err));
          chk("data_rdata",  bus.data_rdata_o, e.rdata);
          chk("instr_quiet", {31'h0, bus.instr_err_o} | bus.instr_rdata_o, 32'h0);
        end else begin
          chk("instr_err",   32'(bus.instr_err_o), 32'(e.err));
          chk("instr_rdata", bus.instr_rdata_o, e.rdata);
          chk("data_quiet",  {31'h0, bus.data_err_o} | bus.data_rdata_o, 32'h0);
        end
      end
    end else begin
      chk("idle_resp", bus.instr_rdata_o | bus.data_rdata_o |
          {30'h0, bus.instr_err_o, bus.data_err_o}, 32'h0);
      if (q.size() != 0 && q[0].due <= cyc) begin
        chk("missing_rvalid", 32'h0, 32'h1);
        void'(q.pop_front());
      end
    end
  end

  task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                      input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd);
    bus.instr_req_i  = ir;
    bus.instr_addr_i = ia;
    bus.data_req_i   = dr;
    bus.data_we_i    = dwe;
    bus.data_be_i    = dbe;
    bus.data_addr_i  = da;
    bus.data_wdata_i = dwd;
    @(negedge clk);
    check_grant();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return {16'($urandom_range(1, 65535)), 14'($urandom), 2'b00};
    return 32'($urandom_range(0, Words - 1)) * 4;
  endfunction

  initial begin
    for (int i = 0; i < Words; i++) begin
      sram[i]    = $urandom;
      ref_mem[i] = sram[i];
    end
    sram[32'h20]    = 32'h00000513;
    ref_mem[32'h20] = 32'h00000513;

    // Reset with both ports requesting: everything must stay silent.
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 32'h80;
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = 4'hF;
    bus.data_addr_i  = 32'h100;
    bus.data_wdata_i = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Instruction fetch of word 0x20.
    step(1, 32'h80, 0, 0, 4'h0, 32'h0, 32'h0);
    // Four contended cycles: data, instr, data, instr.
    for (int i = 0; i < 4; i++)
      step(1, 32'h80 + 32'(4 * i), 1, 0, 4'hF, 32'h200 + 32'(4 * i), 32'h0);
    // Partial write then read-back of 0x100.
    step(0, 32'h0, 1, 1, 4'b0011, 32'h100, 32'hAABBCCDD);
    step(0, 32'h0, 1, 0, 4'hF, 32'h100, 32'h0);
    // Out-of-window data read and instruction fetch, then a good fetch.
    step(0, 32'h0, 1, 0, 4'hF, 32'h00010000, 32'h0);
    step(1, 32'hFFFF0000, 0, 0, 4'h0, 32'h0, 32'h0);
    step(1, 32'h84, 0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 4'($urandom), rand_addr(), $urandom);
    step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Reset right after a data grant: its response must be dropped.
    step(0, 32'h0, 1, 0, 4'hF, 32'h200, 32'h0);
    rst = 1'b1;
    q.delete();
    ncontend = 0;
    bus.instr_req_i = 1'b1;
    bus.data_req_i  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step(1, 32'h40, 1, 0, 4'hF, 32'h44, 32'h0);
    step(1, 32'h48, 1, 0, 4'hF, 32'h4C, 32'h0);
    step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
